mc_ctrl: RTL and testbench

Multicycle control sequencer for the MIPS datapath: the producer of the 4-bit ALU operation code and the consumer of the ALU zero flag. It walks each instruction through fetch, decode, execute, memory and writeback states. It emits all datapath enables, the mux selects and the ALU operation code. It resolves beq from the zero flag and stalls on a memory-ready handshake.

---
 rtl/mc_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_mc_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl.sv
// mc_ctrl: multicycle control sequencer for the MIPS datapath.
//
// Steps each instruction through FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK
// states. It drives the datapath enables, the mux selects and the 4-bit ALU
// operation code. It also resolves beq from the ALU zero flag.
//
// Ports:
//   clk, rst_n      rising-edge clock, asynchronous active-low reset
//   opcode, funct   instruction[31:26] and instruction[5:0] from the IR
//   zero            ALU zero flag, sampled in BRANCH
//   mem_ready       memory completed the current access this cycle
//   operation       ALU code (AND 0000, OR 0001, add 0010, sub 0110,
//                   slt 0111, nor 1100)
//   alusrca/alusrcb ALU operand selects
//   pcsource, pc_en PC next-value select and write enable
//   iord            memory address select (0 = PC, 1 = ALUOut)
//   memread/memwrite memory strobes
//   irwrite         instruction register write enable
//   regdst/memtoreg register file write address / data selects
//   regwrite        register file write enable
//   illegal         one-cycle pulse on an unsupported opcode or funct
//   state           current state, exposed for debug
//
// Memory handshake: the controller holds memread or memwrite, together with
// iord, steady for as long as it waits. An access completes in the cycle
// where the strobe and mem_ready are both high. The FSM advances on that edge
// and not before. mem_ready is ignored outside FETCH, MEMREAD and MEMWRITE.
module mc_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic [3:0] operation,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsource,
    output logic       pc_en,
    output logic       iord,
    output logic       memread,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        RTEXEC   = 4'd6,
        RTWB     = 4'd7,
        BRANCH   = 4'd8,
        JUMP     = 4'd9,
        ADDIEX   = 4'd10,
        ADDIWB   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    state_t cur;

    assign state = cur;

    // State register. Any encoding outside the defined set returns to FETCH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur <= FETCH;
        end else begin
            case (cur)
                FETCH:    if (mem_ready) cur <= DECODE;
                DECODE: begin
                    case (opcode)
                        OP_RTYPE:     cur <= RTEXEC;
                        OP_LW, OP_SW: cur <= MEMADR;
                        OP_BEQ:       cur <= BRANCH;
                        OP_J:         cur <= JUMP;
                        OP_ADDI:      cur <= ADDIEX;
                        default:      cur <= FETCH;
                    endcase
                end
                MEMADR:   cur <= (opcode == OP_LW) ? MEMREAD : MEMWRITE;
                MEMREAD:  if (mem_ready) cur <= MEMWB;
                MEMWB:    cur <= FETCH;
                MEMWRITE: if (mem_ready) cur <= FETCH;
                RTEXEC:   cur <= RTWB;
                RTWB:     cur <= FETCH;
                BRANCH:   cur <= FETCH;
                JUMP:     cur <= FETCH;
                ADDIEX:   cur <= ADDIWB;
                ADDIWB:   cur <= FETCH;
                default:  cur <= FETCH;
            endcase
        end
    end

    // Output decode. It is purely combinational on state and the live inputs.
    always_comb begin
        operation = 4'b0000;
        alusrca   = 1'b0;
        alusrcb   = 2'b00;
        pcsource  = 2'b00;
        pc_en     = 1'b0;
        iord      = 1'b0;
        memread   = 1'b0;
        memwrite  = 1'b0;
        irwrite   = 1'b0;
        regdst    = 1'b0;
        memtoreg  = 1'b0;
        regwrite  = 1'b0;
        illegal   = 1'b0;

        case (cur)
            FETCH: begin
                // PC + 4 is computed every cycle. PC and IR commit only
                // when the fetch completes.
                memread   = 1'b1;
                alusrcb   = 2'b01;
                operation = ALU_ADD;
                irwrite   = mem_ready;
                pc_en     = mem_ready;
            end
            DECODE: begin
                // Speculatively compute the branch target into ALUOut.
                alusrcb   = 2'b11;
                operation = ALU_ADD;
                case (opcode)
                    OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: illegal = 1'b0;
                    default: illegal = 1'b1;
                endcase
            end
            MEMADR, ADDIEX: begin
                alusrca   = 1'b1;
                alusrcb   = 2'b10;
                operation = ALU_ADD;
            end
            MEMREAD: begin
                memread = 1'b1;
                iord    = 1'b1;
            end
            MEMWB: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
            end
            MEMWRITE: begin
                memwrite = 1'b1;
                iord     = 1'b1;
            end
            RTEXEC: begin
                alusrca = 1'b1;
                case (funct)
                    6'b100000: operation = ALU_ADD;
                    6'b100010: operation = ALU_SUB;
                    6'b100100: operation = ALU_AND;
                    6'b100101: operation = ALU_OR;
                    6'b101010: operation = ALU_SLT;
                    6'b100111: operation = ALU_NOR;
                    default: begin
                        // Unknown funct still executes as add and writes back.
                        operation = ALU_ADD;
                        illegal   = 1'b1;
                    end
                endcase
            end
            RTWB: begin
                regwrite = 1'b1;
                regdst   = 1'b1;
            end
            BRANCH: begin
                alusrca   = 1'b1;
                operation = ALU_SUB;
                pcsource  = 2'b01;
                pc_en     = zero;
            end
            JUMP: begin
                pcsource = 2'b10;
                pc_en    = 1'b1;
            end
            ADDIWB: begin
                regwrite = 1'b1;
            end
            default: ;
        endcase

        // While reset is held, state is already FETCH. Suppress every
        // enable and strobe so that nothing is written while reset is low.
        if (!rst_n) begin
            pc_en    = 1'b0;
            irwrite  = 1'b0;
            memread  = 1'b0;
            memwrite = 1'b0;
            regwrite = 1'b0;
            illegal  = 1'b0;
        end
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed testbench for mc_ctrl. Inputs change 1 time unit after a rising
// edge. Outputs are sampled on the falling edge.
module tb_mc_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic [3:0] operation;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsource;
    logic       pc_en;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       illegal;
    logic [3:0] state;

    int n_checks = 0;
    int n_fail   = 0;

    mc_ctrl dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .operation(operation), .alusrca(alusrca),
        .alusrcb(alusrcb), .pcsource(pcsource), .pc_en(pc_en), .iord(iord),
        .memread(memread), .memwrite(memwrite), .irwrite(irwrite),
        .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite),
        .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    initial begin
        #60000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Remain in FETCH and realign to the next rising edge plus 1.
    task automatic park();
        mem_ready = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; opcode = 6'd0; funct = 6'd0; zero = 1'b0; mem_ready = 1'b1;
        tick();
        @(negedge clk);
        n_checks++; if (state !== 4'd0) begin n_fail++; $display("FAIL rst_state got %0d exp 0", state); end
        n_checks++; if ({pc_en, irwrite, memread, memwrite, regwrite} !== 5'b0) begin n_fail++; $display("FAIL rst_strobes got %b exp 00000", {pc_en, irwrite, memread, memwrite, regwrite}); end
        n_checks++; if (operation !== 4'b0010 || alusrcb !== 2'b01) begin n_fail++; $display("FAIL rst_alu got op=%b srcb=%b exp op=0010 srcb=01", operation, alusrcb); end
        n_checks++; if ({illegal, alusrca, pcsource, iord, regdst, memtoreg} !== 7'b0) begin n_fail++; $display("FAIL rst_misc got %b exp 0000000", {illegal, alusrca, pcsource, iord, regdst, memtoreg}); end
        tick();
        rst_n = 1'b1;
        mem_ready = 1'b0;
        @(negedge clk);
        n_checks++; if (state !== 4'd0 || memread !== 1'b1 || pc_en !== 1'b0) begin n_fail++; $display("FAIL fetch_wait got st=%0d mr=%b pc_en=%b exp st=0 mr=1 pc_en=0", state, memread, pc_en); end
        tick();
    endtask

    task automatic test_rtype_add();
        int exp_st[5] = '{0, 1, 6, 7, 0};
        opcode = 6'b000000; funct = 6'b100000; mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++; if (state !== exp_st[i][3:0]) begin n_fail++; $display("FAIL add_state[%0d] got %0d exp %0d", i, state, exp_st[i]); end
            if (i == 0) begin
                n_checks++; if (pc_en !== 1'b1 || irwrite !== 1'b1) begin n_fail++; $display("FAIL add_fetch got pc_en=%b irwrite=%b exp 1 1", pc_en, irwrite); end
            end
            if (exp_st[i] == 6) begin
                n_checks++; if (operation !== 4'b0010 || alusrca !== 1'b1 || alusrcb !== 2'b00) begin n_fail++; $display("FAIL add_exec got op=%b a=%b b=%b exp 0010 1 00", operation, alusrca, alusrcb); end
            end
            n_checks++; if (regwrite !== (exp_st[i] == 7) || regdst !== (exp_st[i] == 7)) begin n_fail++; $display("FAIL add_wb[%0d] got rw=%b rd=%b", i, regwrite, regdst); end
            if (i < 4) tick();
        end
        park();
    endtask

    task automatic test_rtype_ops();
        logic [5:0] fn[6]  = '{6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100111, 6'b000000};
        logic [3:0] op[6]  = '{4'b0110, 4'b0000, 4'b0001, 4'b0111, 4'b1100, 4'b0010};
        logic       ill[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        opcode = 6'b000000; mem_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            funct = fn[k];
            mem_ready = 1'b1;
            tick();
            tick();
            @(negedge clk);
            n_checks++; if (state !== 4'd6 || operation !== op[k]) begin n_fail++; $display("FAIL rt_op funct=%b got st=%0d op=%b exp st=6 op=%b", fn[k], state, operation, op[k]); end
            n_checks++; if (illegal !== ill[k]) begin n_fail++; $display("FAIL rt_illegal funct=%b got %b exp %b", fn[k], illegal, ill[k]); end
            tick();
            @(negedge clk);
            n_checks++; if (state !== 4'd7 || regwrite !== 1'b1 || illegal !== 1'b0) begin n_fail++; $display("FAIL rt_wb funct=%b got st=%0d rw=%b ill=%b exp 7 1 0", fn[k], state, regwrite, illegal); end
            tick();
            @(negedge clk);
            n_checks++; if (state !== 4'd0) begin n_fail++; $display("FAIL rt_ret funct=%b got %0d exp 0", fn[k], state); end
            park();
        end
    endtask

    task automatic test_lw_stall();
        int   exp_st[9] = '{0, 1, 2, 3, 3, 3, 3, 4, 0};
        logic rdy[9]    = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        opcode = 6'b100011; funct = 6'd0;
        for (int i = 0; i < 9; i++) begin
            mem_ready = rdy[i];
            @(negedge clk);
            n_checks++; if (state !== exp_st[i][3:0]) begin n_fail++; $display("FAIL lw_state[%0d] got %0d exp %0d", i, state, exp_st[i]); end
            if (exp_st[i] == 3) begin
                n_checks++; if (memread !== 1'b1 || iord !== 1'b1) begin n_fail++; $display("FAIL lw_memread[%0d] got mr=%b iord=%b exp 1 1", i, memread, iord); end
            end
            if (exp_st[i] == 2) begin
                n_checks++; if (alusrca !== 1'b1 || alusrcb !== 2'b10 || operation !== 4'b0010) begin n_fail++; $display("FAIL lw_memadr got a=%b b=%b op=%b", alusrca, alusrcb, operation); end
            end
            n_checks++; if (regwrite !== (exp_st[i] == 4) || memtoreg !== (exp_st[i] == 4)) begin n_fail++; $display("FAIL lw_wb[%0d] got rw=%b m2r=%b", i, regwrite, memtoreg); end
            if (i < 8) tick();
        end
        park();
    endtask

    task automatic test_beq();
        logic z[2] = '{1'b1, 1'b0};
        opcode = 6'b000100;
        for (int k = 0; k < 2; k++) begin
            zero = z[k];
            mem_ready = 1'b1;
            tick();
            tick();
            @(negedge clk);
            n_checks++; if (state !== 4'd8 || pc_en !== z[k]) begin n_fail++; $display("FAIL beq_pc_en zero=%b got st=%0d pc_en=%b exp st=8 pc_en=%b", z[k], state, pc_en, z[k]); end
            n_checks++; if (pcsource !== 2'b01 || operation !== 4'b0110) begin n_fail++; $display("FAIL beq_sel zero=%b got src=%b op=%b exp 01 0110", z[k], pcsource, operation); end
            tick();
            @(negedge clk);
            n_checks++; if (state !== 4'd0) begin n_fail++; $display("FAIL beq_ret got %0d exp 0", state); end
            park();
        end
        zero = 1'b0;
    endtask

    task automatic test_jump_addi();
        int exp_st[5] = '{0, 1, 10, 11, 0};
        opcode = 6'b000010; mem_ready = 1'b1;
        tick();
        tick();
        @(negedge clk);
        n_checks++; if (state !== 4'd9 || pc_en !== 1'b1 || pcsource !== 2'b10) begin n_fail++; $display("FAIL jump got st=%0d pc_en=%b src=%b exp 9 1 10", state, pc_en, pcsource); end
        tick();
        @(negedge clk);
        n_checks++; if (state !== 4'd0) begin n_fail++; $display("FAIL jump_ret got %0d exp 0", state); end
        park();
        opcode = 6'b001000; mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++; if (state !== exp_st[i][3:0]) begin n_fail++; $display("FAIL addi_state[%0d] got %0d exp %0d", i, state, exp_st[i]); end
            if (exp_st[i] == 10) begin
                n_checks++; if (alusrca !== 1'b1 || alusrcb !== 2'b10) begin n_fail++; $display("FAIL addi_ex got a=%b b=%b exp 1 10", alusrca, alusrcb); end
            end
            if (exp_st[i] == 11) begin
                n_checks++; if (regwrite !== 1'b1 || regdst !== 1'b0 || memtoreg !== 1'b0) begin n_fail++; $display("FAIL addi_wb got rw=%b rd=%b m2r=%b exp 1 0 0", regwrite, regdst, memtoreg); end
            end
            if (i < 4) tick();
        end
        park();
    endtask

    task automatic test_illegal_opcode();
        int exp_st[3] = '{0, 1, 0};
        opcode = 6'b111111; mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++; if (state !== exp_st[i][3:0]) begin n_fail++; $display("FAIL ill_state[%0d] got %0d exp %0d", i, state, exp_st[i]); end
            n_checks++; if (illegal !== (i == 1)) begin n_fail++; $display("FAIL ill_pulse[%0d] got %b exp %b", i, illegal, (i == 1)); end
            n_checks++; if (regwrite !== 1'b0 || memwrite !== 1'b0) begin n_fail++; $display("FAIL ill_writes[%0d] got rw=%b mw=%b exp 0 0", i, regwrite, memwrite); end
            if (i < 2) tick();
        end
        park();
    endtask

    task automatic test_reset_in_memwrite();
        opcode = 6'b101011; mem_ready = 1'b1;
        tick();
        tick();
        tick();
        mem_ready = 1'b0;
        @(negedge clk);
        n_checks++; if (state !== 4'd5 || memwrite !== 1'b1 || iord !== 1'b1) begin n_fail++; $display("FAIL sw_wait got st=%0d mw=%b iord=%b exp 5 1 1", state, memwrite, iord); end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (state !== 4'd0 || memwrite !== 1'b0) begin n_fail++; $display("FAIL async_rst got st=%0d mw=%b exp 0 0", state, memwrite); end
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (state !== 4'd0 || memwrite !== 1'b0 || regwrite !== 1'b0) begin n_fail++; $display("FAIL post_rst got st=%0d mw=%b rw=%b exp 0 0 0", state, memwrite, regwrite); end
        park();
    endtask

    initial begin
        test_reset();
        test_rtype_add();
        test_rtype_ops();
        test_lw_stall();
        test_beq();
        test_jump_addi();
        test_illegal_opcode();
        test_reset_in_memwrite();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
